// File: rtl/mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the MIPS pipeline bench top. Sequences the core reset
// after a start request, counts RUN cycles and retired instructions, and ends
// the run either on halt detection (pc unchanged for HALT_WINDOW consecutive
// cycles) or on a watchdog timeout after MAX_CYCLES RUN cycles.
//
// Optional feature, macro MIPS_RUN_BREAK_EN:
//   When defined, a retiring BREAK instruction (opcode 0, funct 0x0D) ends the
//   run as a halt. When undefined, instr is ignored and halt is by pc
//   stability only.
//
// Parameters:
//   RST_CYCLES  - cycles core_reset stays asserted after start (>= 1)
//   HALT_WINDOW - consecutive equal-pc cycles that declare a halt (>= 2)
//   MAX_CYCLES  - watchdog limit on RUN cycles
//   CNT_W       - width of cycle_count / instr_count
//
// Ports:
//   clk         in   bench clock, rising edge
//   reset       in   synchronous, active-low
//   start       in   run request, sampled in IDLE only
//   pc          in   core program counter
//   retire      in   one instruction retired this cycle
//   instr       in   retiring instruction word (BREAK feature only)
//   core_reset  out  active-high reset to the core
//   running     out  high while the run is in progress
//   done        out  high once the run has ended
//   halted      out  run ended by halt detection
//   timed_out   out  run ended by the watchdog
//   cycle_count out  RUN cycles elapsed (saturating)
//   instr_count out  retires counted in RUN (saturating)
// ---------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HALT_WINDOW = 4,
    parameter int unsigned MAX_CYCLES  = 30,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic             retire,
    input  logic [31:0]      instr,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned RC_W  = $clog2(RST_CYCLES) + 1;
    localparam int unsigned STB_W = $clog2(HALT_WINDOW) + 1;

    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] HALT_HIT = STB_W'(HALT_WINDOW - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [31:0]      pc_prev;
    logic             hist_valid;   // pc_prev holds a pc sampled in this run
    logic [STB_W-1:0] stable;

    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ins_inc;
    logic [STB_W-1:0] stable_nxt;
    logic             halt_hit;
    logic             wd_hit;
    logic             brk_hit;

    // instr is only decoded with the BREAK feature; keep all bits referenced.
    logic unused_instr;
    assign unused_instr = ^instr;

    always_comb begin
        cyc_inc = cycle_count;
        if (cycle_count != '1) begin
            cyc_inc = cycle_count + 1'b1;
        end

        ins_inc = instr_count;
        if (retire && (instr_count != '1)) begin
            ins_inc = instr_count + 1'b1;
        end

        // First RUN cycle always counts as a pc change, even if pc matches
        // the cleared history register.
        stable_nxt = '0;
        if (hist_valid && (pc == pc_prev)) begin
            stable_nxt = stable + 1'b1;
        end

        halt_hit = (stable_nxt == HALT_HIT);
        wd_hit   = (cycle_count == WD_LAST);

`ifdef MIPS_RUN_BREAK_EN
        brk_hit = retire && (instr[31:26] == 6'h00) && (instr[5:0] == 6'h0D);
`else
        brk_hit = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            pc_prev     <= '0;
            hist_valid  <= 1'b0;
            stable      <= '0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_reset <= 1'b1;
                    if (start) begin
                        state   <= S_RST;
                        rst_cnt <= '0;
                    end
                end

                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    // Counters take their increment on the exit edge too.
                    cycle_count <= cyc_inc;
                    instr_count <= ins_inc;
                    pc_prev     <= pc;
                    hist_valid  <= 1'b1;
                    stable      <= stable_nxt;
                    if (halt_hit || brk_hit) begin
                        state      <= S_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        halted     <= 1'b1;
                        core_reset <= 1'b1;
                    end else if (wd_hit) begin
                        state      <= S_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        timed_out  <= 1'b1;
                        core_reset <= 1'b1;
                    end
                end

                S_DONE: begin
                    core_reset <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Run status invariants.
    a_done_one_cause: assert property (@(posedge clk) disable iff (!reset)
        done |-> (halted ^ timed_out));
    a_run_not_reset: assert property (@(posedge clk) disable iff (!reset)
        running |-> !core_reset);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_run_ctrl
//
// Self-checking bench for mips_run_ctrl. A behavioural model tracks the run
// from the observable rules (reset countdown, pc history window, run length)
// and a compare process checks every DUT output on each falling edge.
// Directed scenarios pin the model with literal expectations; a randomized
// phase then drives arbitrary reset/start/pc/retire traffic.
// ---------------------------------------------------------------------------
module tb_mips_run_ctrl;

    localparam int RST_CYCLES  = 2;
    localparam int HALT_WINDOW = 4;
    localparam int MAX_CYCLES  = 30;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      pc;
    logic             retire;
    logic [31:0]      instr;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             halted;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .HALT_WINDOW(HALT_WINDOW),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .retire     (retire),
        .instr      (instr),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .halted     (halted),
        .timed_out  (timed_out),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    bit          e_core_reset, e_running, e_done, e_halted, e_timed_out;
    longint      e_cyc, e_ins;
    int          rst_left;
    bit          in_run, finished;
    logic [31:0] pcq[$];
    longint      cnt_max;

    initial cnt_max = (longint'(1) << CNT_W) - 1;

    always @(posedge clk) begin : model
        bit stop_halt;
        bit stop_wd;
        if (reset === 1'b0) begin
            m_valid      = 1'b1;
            e_core_reset = 1'b1;
            e_running    = 1'b0;
            e_done       = 1'b0;
            e_halted     = 1'b0;
            e_timed_out  = 1'b0;
            e_cyc        = 0;
            e_ins        = 0;
            rst_left     = 0;
            in_run       = 1'b0;
            finished     = 1'b0;
            pcq.delete();
        end else if (!m_valid || finished) begin
            // nothing changes until reset
        end else if (in_run) begin
            if (e_cyc < cnt_max) e_cyc++;
            if (retire && e_ins < cnt_max) e_ins++;
            // Keep the pcs of the last HALT_WINDOW run cycles.
            pcq.push_back(pc);
            if (pcq.size() > HALT_WINDOW) void'(pcq.pop_front());
            stop_halt = (pcq.size() == HALT_WINDOW);
            foreach (pcq[i]) if (pcq[i] != pcq[0]) stop_halt = 1'b0;
`ifdef MIPS_RUN_BREAK_EN
            if (retire && instr[31:26] == 6'h00 && instr[5:0] == 6'h0D) stop_halt = 1'b1;
`endif
            stop_wd = (e_cyc == MAX_CYCLES);
            if (stop_halt || stop_wd) begin
                finished     = 1'b1;
                e_running    = 1'b0;
                e_done       = 1'b1;
                e_core_reset = 1'b1;
                e_halted     = stop_halt;
                e_timed_out  = !stop_halt;
            end
        end else if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) begin
                in_run       = 1'b1;
                e_running    = 1'b1;
                e_core_reset = 1'b0;
            end
        end else if (start) begin
            rst_left = RST_CYCLES;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (core_reset !== e_core_reset || running !== e_running ||
                done !== e_done || halted !== e_halted || timed_out !== e_timed_out ||
                cycle_count !== CNT_W'(e_cyc) || instr_count !== CNT_W'(e_ins)) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t actual cr=%b run=%b done=%b h=%b to=%b cyc=%0d ins=%0d required cr=%b run=%b done=%b h=%b to=%b cyc=%0d ins=%0d",
                         $time, core_reset, running, done, halted, timed_out, cycle_count, instr_count,
                         e_core_reset, e_running, e_done, e_halted, e_timed_out, e_cyc, e_ins);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        retire = 1'b0;
        pc     = '0;
        instr  = '0;
        repeat (2) @(negedge clk);
        check_lit("rst_core_reset", 64'(core_reset), 64'd1);
        check_lit("rst_status", 64'({running, done, halted, timed_out}), 64'd0);
        check_lit("rst_counters", 64'(cycle_count) + 64'(instr_count), 64'd0);
        reset = 1'b1;
    endtask

    // Pulse start for one cycle; returns at the falling edge of RUN cycle 1.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_lit("seq1_core_reset", 64'(core_reset), 64'd1);
        check_lit("seq1_running", 64'(running), 64'd0);
        @(negedge clk);
        check_lit("seq2_core_reset", 64'(core_reset), 64'd1);
        @(negedge clk);
        check_lit("run1_core_reset", 64'(core_reset), 64'd0);
        check_lit("run1_running", 64'(running), 64'd1);
        check_lit("run1_counts", 64'(cycle_count) + 64'(instr_count), 64'd0);
    endtask

    function automatic logic [31:0] pc_fn(input int mode, input int k);
        case (mode)
            0:       return 32'(4 * ((k < 5) ? k : 5));    // climbs to 0x14 then holds
            1:       return 32'(4 * k);                      // never repeats
            default: return 32'(4 * ((k < 27) ? k : 27));   // settles on cycle 27
        endcase
    endfunction

    // Drive run cycle k = 1.. until done rises or the budget runs out.
    task automatic run_pattern(input int mode, input int bound);
        int k;
        k = 1;
        while (done !== 1'b1 && k <= bound) begin
            pc     = pc_fn(mode, k);
            retire = 1'($urandom_range(0, 1));
            instr  = {$urandom} & 32'hFFFF_FFC0 | 32'h20;
            @(negedge clk);
            k++;
        end
        retire = 1'b0;
        check_lit("run_reached_done", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        pc     = '0;
        retire = 1'b0;
        instr  = '0;

        // Reset/start then pc-stable halt.
        do_reset();
        do_start();
        run_pattern(0, 20);
        check_lit("halt_halted", 64'(halted), 64'd1);
        check_lit("halt_timed_out", 64'(timed_out), 64'd0);
        check_lit("halt_cycles", 64'(cycle_count), 64'd8);
        start = 1'b1;                       // ignored in DONE
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_lit("halt_frozen", 64'(cycle_count), 64'd8);
        check_lit("halt_core_reset", 64'(core_reset), 64'd1);

        // Watchdog.
        do_reset();
        do_start();
        run_pattern(1, 40);
        check_lit("wd_timed_out", 64'(timed_out), 64'd1);
        check_lit("wd_halted", 64'(halted), 64'd0);
        check_lit("wd_cycles", 64'(cycle_count), 64'd30);
        check_lit("wd_core_reset", 64'(core_reset), 64'd1);

        // Halt and watchdog on the same edge.
        do_reset();
        do_start();
        run_pattern(2, 40);
        check_lit("sim_halted", 64'(halted), 64'd1);
        check_lit("sim_timed_out", 64'(timed_out), 64'd0);
        check_lit("sim_cycles", 64'(cycle_count), 64'd30);

        // Reset during RUN cycle 10, then a clean rerun.
        do_reset();
        do_start();
        for (int k = 1; k <= 9; k++) begin
            pc     = 32'(4 * k);
            retire = 1'b1;
            @(negedge clk);
        end
        check_lit("mid_cycles", 64'(cycle_count), 64'd9);
        check_lit("mid_instrs", 64'(instr_count), 64'd9);
        reset  = 1'b0;
        retire = 1'b0;
        @(negedge clk);
        check_lit("abort_core_reset", 64'(core_reset), 64'd1);
        check_lit("abort_status", 64'({running, done, halted, timed_out}), 64'd0);
        check_lit("abort_counters", 64'(cycle_count) + 64'(instr_count), 64'd0);
        reset = 1'b1;
        do_start();
        run_pattern(0, 20);
        check_lit("rerun_cycles", 64'(cycle_count), 64'd8);

        // BREAK retiring at RUN cycle 7.
        do_reset();
        do_start();
        for (int k = 1; k <= 7; k++) begin
            pc     = 32'(4 * k);
            retire = (k == 7);
            instr  = (k == 7) ? 32'h0000_000D : 32'h0000_0020;
            @(negedge clk);
        end
        retire = 1'b0;
        instr  = '0;
`ifdef MIPS_RUN_BREAK_EN
        check_lit("brk_done", 64'(done), 64'd1);
        check_lit("brk_halted", 64'(halted), 64'd1);
        check_lit("brk_instrs", 64'(instr_count), 64'd1);
        check_lit("brk_cycles", 64'(cycle_count), 64'd7);
`else
        check_lit("brk_running", 64'(running), 64'd1);
        check_lit("brk_instrs", 64'(instr_count), 64'd1);
        for (int k = 8; k <= 40 && done !== 1'b1; k++) begin
            pc = 32'(4 * k);
            @(negedge clk);
        end
        check_lit("brk_wd_timed_out", 64'(timed_out), 64'd1);
`endif

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            reset  = ($urandom_range(0, 79) != 0);
            start  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) pc = pc + 32'd4;
            retire = 1'($urandom_range(0, 1));
            instr  = ($urandom_range(0, 9) == 0) ? 32'h0000_000D : ({$urandom} | 32'h3F);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
